audio_mixer: RTL and testbench

- Synthesizable N-channel stereo mixer that replaces the bench-only sum-and-gain path behind the wave generators.
- Once per sample period it collects one sample from each enabled channel over ready/valid handshakes.
- Each sample gets independent left/right gains. Samples are multiply-accumulated sequentially, saturated to width_p, and presented as a stereo pair on a ready/valid output.
- Sits between the generator instances and the audio sink/codec serializer.

---
 rtl/audio_mixer.sv | 172 +++++++++++++++++
 tb/tb_audio_mixer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
// N-channel stereo mixer: collects one sample per channel each sample tick,
// applies per-channel left/right gains with a sequential MAC, saturates, and presents the pair.
module audio_mixer #(
    parameter int width_p      = 24,
    parameter int num_ch_p     = 4,
    parameter int gain_width_p = 8,
    parameter int clk_div_p    = 385
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic [num_ch_p*width_p-1:0]      ch_data_i,
    input  logic [num_ch_p-1:0]              ch_valid_i,
    output logic [num_ch_p-1:0]              ch_ready_o,
    input  logic [num_ch_p-1:0]              enable_i,
    input  logic [num_ch_p*gain_width_p-1:0] gain_l_i,
    input  logic [num_ch_p*gain_width_p-1:0] gain_r_i,
    output logic [width_p-1:0]               data_l_o,
    output logic [width_p-1:0]               data_r_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic                             clip_o,
    output logic                             overrun_o,
    input  logic                             clr_i
);

    localparam int ACC_W  = width_p + gain_width_p + $clog2(num_ch_p) + 1;
    localparam int PROD_W = width_p + gain_width_p + 1;
    localparam int CNT_W  = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;
    localparam int IDX_W  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clk_div_p - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(num_ch_p - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-width_p+1){1'b0}}, {(width_p-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-width_p+1){1'b1}}, {(width_p-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, COLLECT, MAC, SAT, OUT} state_t;

    state_t                            state;
    logic [CNT_W-1:0]                  cnt;
    logic                              tick;
    logic [num_ch_p-1:0]               en_q;
    logic [num_ch_p-1:0]               got;
    logic [num_ch_p-1:0]               fire;
    logic                              collect_done;
    logic signed [width_p-1:0]         smp [num_ch_p];
    logic [num_ch_p*gain_width_p-1:0]  gain_l_q;
    logic [num_ch_p*gain_width_p-1:0]  gain_r_q;
    logic [IDX_W-1:0]                  idx;
    logic signed [ACC_W-1:0]           acc_l;
    logic signed [ACC_W-1:0]           acc_r;

    logic signed [width_p-1:0]         cur_smp;
    logic [gain_width_p-1:0]           cur_gain_l;
    logic [gain_width_p-1:0]           cur_gain_r;
    logic signed [PROD_W-1:0]          prod_l;
    logic signed [PROD_W-1:0]          prod_r;
    logic signed [PROD_W-1:0]          prod_sh_l;
    logic signed [PROD_W-1:0]          prod_sh_r;
    logic signed [ACC_W-1:0]           term_l;
    logic signed [ACC_W-1:0]           term_r;
    logic [width_p-1:0]                sat_l;
    logic [width_p-1:0]                sat_r;
    logic                              clip_l;
    logic                              clip_r;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            cnt <= '0;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick         = (cnt == CNT_LAST);
    assign ch_ready_o   = (state == COLLECT) ? (en_q & ~got) : '0;
    assign fire         = ch_ready_o & ch_valid_i;
    assign collect_done = ((en_q & ~(got | fire)) == '0);

    // Uncaptured channels (disabled or timed out) feed zero into the MAC.
    always_comb begin
        cur_smp    = got[idx] ? smp[idx] : '0;
        cur_gain_l = gain_l_q[int'(idx)*gain_width_p +: gain_width_p];
        cur_gain_r = gain_r_q[int'(idx)*gain_width_p +: gain_width_p];
        prod_l     = PROD_W'(cur_smp) * PROD_W'($signed({1'b0, cur_gain_l}));
        prod_r     = PROD_W'(cur_smp) * PROD_W'($signed({1'b0, cur_gain_r}));
        prod_sh_l  = prod_l >>> (gain_width_p - 1);
        prod_sh_r  = prod_r >>> (gain_width_p - 1);
        term_l     = ACC_W'(prod_sh_l);
        term_r     = ACC_W'(prod_sh_r);
    end

    always_comb begin
        clip_l = (acc_l > SAT_MAX) || (acc_l < SAT_MIN);
        clip_r = (acc_r > SAT_MAX) || (acc_r < SAT_MIN);
        sat_l  = (acc_l > SAT_MAX) ? SAT_MAX[width_p-1:0] :
                 (acc_l < SAT_MIN) ? SAT_MIN[width_p-1:0] : acc_l[width_p-1:0];
        sat_r  = (acc_r > SAT_MAX) ? SAT_MAX[width_p-1:0] :
                 (acc_r < SAT_MIN) ? SAT_MIN[width_p-1:0] : acc_r[width_p-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            en_q      <= '0;
            got       <= '0;
            gain_l_q  <= '0;
            gain_r_q  <= '0;
            idx       <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            data_l_o  <= '0;
            data_r_o  <= '0;
            valid_o   <= 1'b0;
            clip_o    <= 1'b0;
            overrun_o <= 1'b0;
            for (int k = 0; k < num_ch_p; k++)
                smp[k] <= '0;
        end else begin
            // A tick anywhere but IDLE is an overrun; setting beats clearing.
            if (tick && state != IDLE)
                overrun_o <= 1'b1;
            else if (clr_i)
                overrun_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (tick) begin
                        en_q  <= enable_i;
                        got   <= '0;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    for (int k = 0; k < num_ch_p; k++)
                        if (fire[k])
                            smp[k] <= ch_data_i[k*width_p +: width_p];
                    got <= got | fire;
                    if (tick || collect_done) begin
                        gain_l_q <= gain_l_i;
                        gain_r_q <= gain_r_i;
                        idx      <= '0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc_l <= acc_l + term_l;
                    acc_r <= acc_r + term_r;
                    idx   <= idx + 1'b1;
                    if (idx == IDX_LAST)
                        state <= SAT;
                end
                SAT: begin
                    data_l_o <= sat_l;
                    data_r_o <= sat_r;
                    clip_o   <= clip_l | clip_r;
                    valid_o  <= 1'b1;
                    state    <= OUT;
                end
                OUT: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        acc_l   <= '0;
                        acc_r   <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: randomized and directed sample periods checked
// against a floor-division / clamp reference model.
module tb_audio_mixer;

    localparam int W   = 24;
    localparam int N   = 4;
    localparam int G   = 8;
    localparam int DIV = 385;

    logic           clk_i = 1'b0;
    logic           reset_ni;
    logic [N*W-1:0] ch_data_i;
    logic [N-1:0]   ch_valid_i;
    logic [N-1:0]   ch_ready_o;
    logic [N-1:0]   enable_i;
    logic [N*G-1:0] gain_l_i;
    logic [N*G-1:0] gain_r_i;
    logic [W-1:0]   data_l_o;
    logic [W-1:0]   data_r_o;
    logic           valid_o;
    logic           ready_i;
    logic           clip_o;
    logic           overrun_o;
    logic           clr_i;

    always #5 clk_i = ~clk_i;

    audio_mixer #(.width_p(W), .num_ch_p(N), .gain_width_p(G), .clk_div_p(DIV)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .ch_data_i  (ch_data_i),
        .ch_valid_i (ch_valid_i),
        .ch_ready_o (ch_ready_o),
        .enable_i   (enable_i),
        .gain_l_i   (gain_l_i),
        .gain_r_i   (gain_r_i),
        .data_l_o   (data_l_o),
        .data_r_o   (data_r_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .clip_o     (clip_o),
        .overrun_o  (overrun_o),
        .clr_i      (clr_i)
    );

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic         clip;
    } exp_t;

    int   checks    = 0;
    int   errors    = 0;
    int   out_count = 0;
    exp_t exp_q[$];
    exp_t exp_cur;

    int samp[N];
    int gl[N];
    int gr[N];
    bit en[N];
    bit vld[N];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout expected=event", name);
    endtask

    function automatic longint floorDiv(input longint p, input longint d);
        longint q = p / d;
        if ((p % d) != 0 && p < 0)
            q = q - 1;
        return q;
    endfunction

    function automatic void satClamp(input longint sum, output logic [W-1:0] v, output bit clipped);
        longint maxv = (longint'(1) <<< (W-1)) - 1;
        longint minv = -(longint'(1) <<< (W-1));
        clipped = 1'b1;
        if (sum > maxv)
            v = W'(maxv);
        else if (sum < minv)
            v = W'(minv);
        else begin
            v = W'(sum);
            clipped = 1'b0;
        end
    endfunction

    // Each enabled channel that actually presents data contributes floor(s*g/2^(G-1)).
    function automatic exp_t modelMix();
        exp_t   e;
        longint sl = 0;
        longint sr = 0;
        bit     cl;
        bit     cr;
        for (int k = 0; k < N; k++) begin
            if (en[k] && vld[k]) begin
                sl += floorDiv(longint'(samp[k]) * gl[k], longint'(1) <<< (G-1));
                sr += floorDiv(longint'(samp[k]) * gr[k], longint'(1) <<< (G-1));
            end
        end
        satClamp(sl, e.l, cl);
        satClamp(sr, e.r, cr);
        e.clip = cl | cr;
        return e;
    endfunction

    always @(negedge clk_i) begin
        if (reset_ni && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output actual=%h_%h expected=none", data_l_o, data_r_o);
            end else begin
                exp_cur = exp_q.pop_front();
                checkOutput("data_l", 32'(data_l_o), 32'(exp_cur.l));
                checkOutput("data_r", 32'(data_r_o), 32'(exp_cur.r));
                checkOutput("clip",   32'(clip_o),   32'(exp_cur.clip));
            end
            out_count++;
        end
    end

    task automatic applyStimulus(input bit push);
        for (int k = 0; k < N; k++) begin
            ch_data_i[k*W +: W] = W'(samp[k]);
            ch_valid_i[k]       = vld[k];
            enable_i[k]         = en[k];
            gain_l_i[k*G +: G]  = G'(gl[k]);
            gain_r_i[k*G +: G]  = G'(gr[k]);
        end
        if (push)
            exp_q.push_back(modelMix());
    endtask

    task automatic randomRound();
        int mode;
        for (int k = 0; k < N; k++) begin
            en[k]  = 1'($urandom_range(0, 1));
            vld[k] = 1'b1;
            mode   = int'($urandom_range(0, 5));
            if (mode == 0)
                samp[k] = 32'h007F_FFFF;
            else if (mode == 1)
                samp[k] = -32'sd8388608;
            else
                samp[k] = int'($urandom_range(0, 32'h00FF_FFFF)) - 8388608;
            gl[k] = int'($urandom_range(0, 255));
            gr[k] = int'($urandom_range(0, 255));
        end
    endtask

    task automatic setAll(input int s, input int g);
        for (int k = 0; k < N; k++) begin
            en[k] = 1'b1; vld[k] = 1'b1; samp[k] = s; gl[k] = g; gr[k] = g;
        end
    endtask

    task automatic waitValid(input string name);
        int cyc = 0;
        while (!valid_o && cyc < 3*DIV) begin
            @(negedge clk_i);
            cyc++;
        end
        if (!valid_o)
            timeoutFail(name);
    endtask

    task automatic waitOutput(input int prev, input string name, output int cyc);
        cyc = 0;
        while (out_count == prev && cyc < 3*DIV) begin
            @(negedge clk_i);
            cyc++;
        end
        if (out_count == prev)
            timeoutFail(name);
    endtask

    task automatic runRound(input bit stall);
        int prev = out_count;
        int cyc;
        applyStimulus(1'b1);
        if (stall) begin
            ready_i = 1'b0;
            waitValid("stall_valid");
            repeat ($urandom_range(1, 6)) @(negedge clk_i);
            ready_i = 1'b1;
        end
        waitOutput(prev, "round_output", cyc);
    endtask

    task automatic runLatencyRound();
        int prev = out_count;
        int cyc  = 0;
        int n    = 0;
        applyStimulus(1'b1);
        while (!ch_ready_o[0] && cyc < 2*DIV) begin
            @(negedge clk_i);
            cyc++;
        end
        if (!ch_ready_o[0])
            timeoutFail("latency_ready");
        else begin
            while (!valid_o && n < 50) begin
                @(negedge clk_i);
                n++;
            end
            checkOutput("latency", 32'(n - 1), 32'(N + 1));
        end
        waitOutput(prev, "latency_output", cyc);
    endtask

    initial begin
        int  prev;
        int  cyc;
        bit  bad_hold;
        bit  valid_drop;
        bit  ready_seen;
        logic [W-1:0] held_l;
        logic [W-1:0] held_r;
        logic         held_clip;

        reset_ni   = 1'b0;
        ch_data_i  = '0;
        ch_valid_i = '0;
        enable_i   = '0;
        gain_l_i   = '0;
        gain_r_i   = '0;
        ready_i    = 1'b1;
        clr_i      = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_data_l",   32'(data_l_o),   0);
        checkOutput("rst_data_r",   32'(data_r_o),   0);
        checkOutput("rst_valid",    32'(valid_o),    0);
        checkOutput("rst_clip",     32'(clip_o),     0);
        checkOutput("rst_overrun",  32'(overrun_o),  0);
        checkOutput("rst_ch_ready", 32'(ch_ready_o), 0);
        reset_ni = 1'b1;

        setAll(0, 128);
        en[1] = 1'b0; en[2] = 1'b0; en[3] = 1'b0;
        samp[0] = 32'h0010_0000;
        runLatencyRound();

        setAll(32'h007F_FFFF, 128);
        runRound(1'b0);
        setAll(-32'sd8388608, 128);
        runRound(1'b0);

        setAll(0, 0);
        for (int k = 0; k < N; k++) en[k] = (k == 1);
        samp[1] = -32'sd2097152; gl[1] = 64; gr[1] = 255;
        runRound(1'b0);

        // Channel 2 never presents data: the following tick forces the MAC.
        randomRound();
        for (int k = 0; k < N; k++) en[k] = 1'b1;
        vld[2] = 1'b0;
        runRound(1'b0);
        checkOutput("overrun_set", 32'(overrun_o), 1);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        checkOutput("overrun_clr", 32'(overrun_o), 0);

        for (int i = 0; i < 20; i++) begin
            randomRound();
            runRound(1'($urandom_range(0, 3) == 0));
        end

        // Downstream stalls across two ticks.
        ready_i = 1'b0;
        randomRound();
        for (int k = 0; k < N; k++) en[k] = 1'b1;
        applyStimulus(1'b1);
        waitValid("hold_valid_rise");
        held_l = data_l_o; held_r = data_r_o; held_clip = clip_o;
        bad_hold = 0; valid_drop = 0; ready_seen = 0;
        repeat (2*DIV + 20) begin
            @(negedge clk_i);
            if (data_l_o !== held_l || data_r_o !== held_r || clip_o !== held_clip) bad_hold = 1;
            if (!valid_o) valid_drop = 1;
            if (ch_ready_o != '0) ready_seen = 1;
        end
        checkOutput("hold_data_stable", 32'(bad_hold),   0);
        checkOutput("hold_valid_high",  32'(valid_drop), 0);
        checkOutput("hold_no_ready",    32'(ready_seen), 0);
        checkOutput("hold_overrun",     32'(overrun_o),  1);
        prev = out_count;
        ready_i = 1'b1;
        waitOutput(prev, "hold_release", cyc);
        randomRound();
        runRound(1'b0);

        // Reset pulsed while the MAC is running.
        randomRound();
        en[0] = 1'b1;
        applyStimulus(1'b0);
        cyc = 0;
        while (ch_ready_o == '0 && cyc < 2*DIV) begin
            @(negedge clk_i);
            cyc++;
        end
        if (ch_ready_o == '0)
            timeoutFail("mac_reset_ready");
        @(negedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b0;
        #1;
        checkOutput("mac_rst_data_l",   32'(data_l_o),   0);
        checkOutput("mac_rst_data_r",   32'(data_r_o),   0);
        checkOutput("mac_rst_valid",    32'(valid_o),    0);
        checkOutput("mac_rst_clip",     32'(clip_o),     0);
        checkOutput("mac_rst_overrun",  32'(overrun_o),  0);
        checkOutput("mac_rst_ch_ready", 32'(ch_ready_o), 0);
        repeat (3) @(negedge clk_i);
        reset_ni = 1'b1;
        randomRound();
        prev = out_count;
        applyStimulus(1'b1);
        waitOutput(prev, "post_reset_output", cyc);
        checkOutput("post_reset_delay_ok", 32'(cyc >= DIV), 1);

        for (int i = 0; i < 6; i++) begin
            randomRound();
            runRound(1'b0);
        end

        repeat (3) @(negedge clk_i);
        checkOutput("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
